// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants for the Q16.16 fixed-point to IEEE754 single-precision
// encode path: operand format, float field widths and the bit positions of
// the sign / exponent / mantissa fields inside a packed single.
// -----------------------------------------------------------------------------
package fp_pkg;

  // Fixed-point operand format (two's complement Q16.16)
  localparam int FIXED_W   = 32;
  localparam int FRAC_BITS = 16;

  // IEEE754 single-precision format
  localparam int EXP_BIAS  = 127;
  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;

  // Field slices of a packed single {sign, exp[7:0], mantissa[22:0]}
  localparam int SIGN_BIT  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int MANT_MSB  = 22;
  localparam int MANT_LSB  = 0;

  // Width of a bit index into a fixed-point operand
  localparam int LZ_W      = $clog2(FIXED_W);

endpackage

// File: rtl/fp_encode_core.sv
// -----------------------------------------------------------------------------
// fp_encode_core
// Purely combinational Q16.16 -> IEEE754 single-precision conversion.
// A zero operand encodes as +0.0; every other operand is normal.
//
// Configuration macro:
//   ROUND_NEAREST_EN  defined   : mantissa rounded to nearest-even (guard +
//                                 sticky from the shifted-out bits)
//                     undefined : mantissa truncated
//
// Ports:
//   i_fixed    in   FIXED_W  Q16.16 two's complement operand
//   o_ieee754  out  32       {sign, exp[7:0], mantissa[22:0]}
// -----------------------------------------------------------------------------
module fp_encode_core
  import fp_pkg::*;
(
  input  logic signed [FIXED_W-1:0] i_fixed,
  output logic        [FIXED_W-1:0] o_ieee754
);

  logic               w_sign;
  logic [FIXED_W-1:0] w_mag;
  logic [LZ_W-1:0]    w_lead;
  logic [FIXED_W-1:0] w_norm;
  logic [MANT_W-1:0]  w_mant_t;
  logic [EXP_W-1:0]   w_exp_base;
  logic [MANT_W-1:0]  w_mant;
  logic [EXP_W-1:0]   w_exp;

  assign w_sign = i_fixed[SIGN_BIT];
  // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign w_mag  = w_sign ? $unsigned(-i_fixed) : $unsigned(i_fixed);

  // Position of the leading one (highest set bit wins).
  always_comb begin
    w_lead = '0;
    for (int i = 0; i < FIXED_W; i++) begin
      if (w_mag[i]) w_lead = LZ_W'(i);
    end
  end

  // Move the leading one to the MSB; the mantissa then sits directly below it
  // and everything under the mantissa is the shifted-out remainder.
  assign w_norm     = w_mag << (LZ_W'(FIXED_W - 1) - w_lead);
  assign w_mant_t   = MANT_W'(w_norm >> (FIXED_W - 1 - MANT_W));
  assign w_exp_base = EXP_W'(EXP_BIAS - FRAC_BITS) + EXP_W'(w_lead);

`ifdef ROUND_NEAREST_EN
  // Returns {carry, mantissa}; the carry means the mantissa wrapped to zero.
  function automatic logic [MANT_W:0] round_rne(input logic [MANT_W-1:0] mant,
                                                input logic              guard,
                                                input logic              sticky);
    logic inc;
    inc = guard & (sticky | mant[0]);
    return {1'b0, mant} + (MANT_W + 1)'(inc);
  endfunction

  logic [MANT_W:0] w_rnd;

  assign w_rnd  = round_rne(w_mant_t,
                            w_norm[FIXED_W - 2 - MANT_W],
                            |w_norm[FIXED_W - 3 - MANT_W:0]);
  assign w_mant = w_rnd[MANT_W-1:0];
  assign w_exp  = w_exp_base + EXP_W'(w_rnd[MANT_W]);
`else
  assign w_mant = w_mant_t;
  assign w_exp  = w_exp_base;
`endif

  always_comb begin
    o_ieee754 = '0;
    if (w_mag != '0) begin
      o_ieee754[SIGN_BIT]         = w_sign;
      o_ieee754[EXP_MSB:EXP_LSB]  = w_exp;
      o_ieee754[MANT_MSB:MANT_LSB] = w_mant;
    end
  end

endmodule

// File: rtl/fp_encode_arbiter.sv
// -----------------------------------------------------------------------------
// fp_encode_arbiter
// Round-robin shares one Q16.16 -> IEEE754 encoder between NUM_REQ
// requesters. Two registered stages: stage 0 captures the granted operand,
// stage 1 holds the encoded result and the winning requester's ID.
// Accept-to-out_valid latency is two cycles; one result per cycle sustained.
//
// Configuration macro (used inside fp_encode_core):
//   ROUND_NEAREST_EN  round mantissa to nearest-even instead of truncating
//
// Ports:
//   clk          in   1               rising-edge clock
//   rst          in   1               asynchronous reset, active-high
//   req_valid    in   NUM_REQ         per-requester valid
//   req_ready    out  NUM_REQ         per-requester ready (one-hot or zero)
//   req_data     in   NUM_REQ*32      Q16.16 operands, requester i at [32*i+:32]
//   out_valid    out  1               result valid
//   out_ready    in   1               consumer ready
//   out_ieee754  out  32              encoded single-precision result
//   out_id       out  ID_W            requester ID of the result
// -----------------------------------------------------------------------------
module fp_encode_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FIXED_W-1:0] req_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIXED_W-1:0]         out_ieee754,
  output logic [ID_W-1:0]            out_id
);

  logic [ID_W-1:0]           r_rr_ptr;
  logic                      r_vld_p0;
  logic signed [FIXED_W-1:0] r_data_p0;
  logic [ID_W-1:0]           r_id_p0;
  logic                      r_vld_p1;
  logic [FIXED_W-1:0]        r_ieee_p1;
  logic [ID_W-1:0]           r_id_p1;

  logic                      w_s1_load;
  logic                      w_s0_load;
  logic                      w_found;
  logic [ID_W-1:0]           w_win;
  logic                      w_grant;
  logic [FIXED_W-1:0]        w_req_arr [NUM_REQ];
  logic [FIXED_W-1:0]        w_ieee_enc;

  assign w_s1_load = !r_vld_p1 || out_ready;
  assign w_s0_load = !r_vld_p0 || w_s1_load;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_arr[i] = req_data[FIXED_W*i +: FIXED_W];
    end
  end

  // Round-robin search from r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!w_found && req_valid[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  // Held low during reset so no requester sees a handshake it cannot complete.
  assign w_grant = w_found && w_s0_load && !rst;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win] = 1'b1;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_ieee_p1 <= '0;
      r_id_p1   <= '0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
      end
      if (w_s0_load) r_vld_p0 <= w_grant;
      if (w_s1_load) r_vld_p1 <= r_vld_p0;
      // Stage 1 boundary: encoded result registered with its requester ID
      if (w_s1_load && r_vld_p0) begin
        r_ieee_p1 <= w_ieee_enc;
        r_id_p1   <= r_id_p0;
      end
    end
  end

  // Stage 0 boundary: granted operand captured (qualified by r_vld_p0)
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_data_p0 <= $signed(w_req_arr[w_win]);
      r_id_p0   <= w_win;
    end
  end

  fp_encode_core u_core (
    .i_fixed   (r_data_p0),
    .o_ieee754 (w_ieee_enc)
  );

  assign out_valid   = r_vld_p1;
  assign out_ieee754 = r_ieee_p1;
  assign out_id      = r_id_p1;

endmodule
